// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if
// Purpose: groups the core-facing handshake of the instruction fetch queue.
// Signals:
//   ovalid     - head entry valid (queue -> core)
//   oinstr     - head instruction word (queue -> core)
//   opc        - address of the head instruction (queue -> core)
//   ocount     - number of queued entries (queue -> core)
//   iready     - core accepts the head this cycle (core -> queue)
//   iflush     - redirect, discard all entries (core -> queue)
//   iflush_pc  - redirect target (core -> queue)
interface ifetch_queue_if #(
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_DEPTH      = 4
);
  logic                         ovalid;
  logic [MP_DATA_WIDTH-1:0]     oinstr;
  logic [31:0]                  opc;
  logic [$clog2(MP_DEPTH):0]    ocount;
  logic                         iready;
  logic                         iflush;
  logic [31:0]                  iflush_pc;

  // Queue side.
  modport master (
    output ovalid, oinstr, opc, ocount,
    input  iready, iflush, iflush_pc
  );

  // Core side.
  modport slave (
    input  ovalid, oinstr, opc, ocount,
    output iready, iflush, iflush_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue
// Purpose: prefetch queue between an instruction memory with combinational
// read and the core. Every cycle with room (or with a simultaneous pop) it
// captures the word at the fetch PC and advances the PC by 4. The core pops
// the head with a valid/ready handshake; a flush discards everything and
// restarts fetching at the word-aligned redirect target.
// Ports:
//   iclk        - clock, rising edge
//   irst        - synchronous active-high reset
//   omem_addr   - fetch address to the instruction memory
//   imem_rdata  - memory word for omem_addr, same cycle
//   core        - ifetch_queue_if.master: ovalid/oinstr/opc/ocount out,
//                 iready/iflush/iflush_pc in
module ifetch_queue #(
  parameter int          MP_DATA_WIDTH = 32,
  parameter int          MP_DEPTH      = 4,
  parameter logic [31:0] MP_RESET_PC   = 32'h0000_0000
) (
  input  logic                     iclk,
  input  logic                     irst,
  output logic [31:0]              omem_addr,
  input  logic [MP_DATA_WIDTH-1:0] imem_rdata,
  ifetch_queue_if.master           core
);

  localparam int LP_PW = $clog2(MP_DEPTH);
  localparam int LP_CW = LP_PW + 1;
  localparam logic [LP_CW-1:0] LP_FULL = LP_CW'(MP_DEPTH);

  logic [31:0]              r_pc;
  logic [LP_PW-1:0]         r_wr_ptr;
  logic [LP_PW-1:0]         r_rd_ptr;
  logic [LP_CW-1:0]         r_count;
  logic [MP_DATA_WIDTH-1:0] r_instr_mem [MP_DEPTH];
  logic [31:0]              r_pc_mem    [MP_DEPTH];

  logic w_valid;
  logic w_pop;
  logic w_push;
  logic w_full;

  assign w_full  = (r_count == LP_FULL);
  // Reset also masks the head so nothing stale is offered while irst is high.
  assign w_valid = (r_count != '0) && !core.iflush && !irst;
  assign w_pop   = w_valid && core.iready;
  // A pop in the same cycle frees the slot being written, so a full queue
  // can still stream one word per cycle.
  assign w_push  = !core.iflush && !irst && (!w_full || w_pop);

  // During the first reset cycle the register may still hold an old PC;
  // the mux keeps the memory address at the reset PC for the whole reset.
  assign omem_addr   = irst ? MP_RESET_PC : r_pc;
  assign core.ovalid = w_valid;
  assign core.oinstr = w_valid ? r_instr_mem[r_rd_ptr] : '0;
  assign core.opc    = w_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign core.ocount = irst ? '0 : r_count;

  // Control state: reset beats flush, flush beats push/pop.
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_pc     <= MP_RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (core.iflush) begin
      r_pc     <= {core.iflush_pc[31:2], 2'b00};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + 32'd4;        // wraps modulo 2^32 naturally
        r_wr_ptr <= r_wr_ptr + 1'b1;     // power-of-two depth: wraps naturally
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage: no reset needed, the count qualifies every read.
  for (genvar gi = 0; gi < MP_DEPTH; gi++) begin : g_entry
    always_ff @(posedge iclk) begin
      if (w_push && (r_wr_ptr == LP_PW'(gi))) begin
        r_instr_mem[gi] <= imem_rdata;
        r_pc_mem[gi]    <= omem_addr;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // DUT 0: default reset PC
  logic        irst0;
  logic [31:0] addr0;
  logic [31:0] rdata0;
  ifetch_queue_if #(.MP_DATA_WIDTH(32), .MP_DEPTH(4)) bus0 ();

  ifetch_queue #(.MP_DATA_WIDTH(32), .MP_DEPTH(4), .MP_RESET_PC(32'h0000_0000)) dut0 (
    .iclk(clk), .irst(irst0), .omem_addr(addr0), .imem_rdata(rdata0), .core(bus0.master)
  );

  // DUT 1: reset PC near the top of the address space
  logic        irst1;
  logic [31:0] addr1;
  logic [31:0] rdata1;
  ifetch_queue_if #(.MP_DATA_WIDTH(32), .MP_DEPTH(4)) bus1 ();

  ifetch_queue #(.MP_DATA_WIDTH(32), .MP_DEPTH(4), .MP_RESET_PC(32'hFFFF_FFF8)) dut1 (
    .iclk(clk), .irst(irst1), .omem_addr(addr1), .imem_rdata(rdata1), .core(bus1.master)
  );

  // Memory model: word k holds 0x1000_0000 + k
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign rdata0 = mem_word(addr0);
  assign rdata1 = mem_word(addr1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        fl;
    logic [31:0] flpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] ecnt;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t mkv(input logic rst, input logic rdy, input logic fl,
                               input logic [31:0] flpc, input logic ev,
                               input logic [31:0] epc, input logic [31:0] einstr,
                               input logic [31:0] ecnt, input logic [31:0] eaddr);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.fl = fl; v.flpc = flpc; v.ev = ev;
    v.epc = epc; v.einstr = einstr; v.ecnt = ecnt; v.eaddr = eaddr;
    return v;
  endfunction

  vec_t vecs[26];

  initial begin
    logic [31:0] exp_pc;
    int          pops;
    logic        fl;
    logic        rdy;
    logic [31:0] tgt;

    irst0 = 1'b1; bus0.iready = 1'b0; bus0.iflush = 1'b0; bus0.iflush_pc = '0;
    irst1 = 1'b1; bus1.iready = 1'b1; bus1.iflush = 1'b0; bus1.iflush_pc = '0;

    //            rst rdy fl flpc          v  opc           instr          cnt addr
    vecs[0]  = mkv(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,         0, 32'h0);
    vecs[1]  = mkv(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,         0, 32'h0);
    vecs[2]  = mkv(0, 0, 0, 32'h0,        1, 32'h0,        32'h1000_0000, 1, 32'h4);
    vecs[3]  = mkv(0, 0, 0, 32'h0,        1, 32'h0,        32'h1000_0000, 2, 32'h8);
    vecs[4]  = mkv(0, 0, 0, 32'h0,        1, 32'h0,        32'h1000_0000, 3, 32'hC);
    vecs[5]  = mkv(0, 0, 0, 32'h0,        1, 32'h0,        32'h1000_0000, 4, 32'h10);
    vecs[6]  = mkv(0, 0, 0, 32'h0,        1, 32'h0,        32'h1000_0000, 4, 32'h10);
    vecs[7]  = mkv(0, 1, 0, 32'h0,        1, 32'h0,        32'h1000_0000, 4, 32'h10);
    vecs[8]  = mkv(0, 1, 0, 32'h0,        1, 32'h4,        32'h1000_0001, 4, 32'h14);
    vecs[9]  = mkv(0, 1, 0, 32'h0,        1, 32'h8,        32'h1000_0002, 4, 32'h18);
    vecs[10] = mkv(0, 1, 0, 32'h0,        1, 32'hC,        32'h1000_0003, 4, 32'h1C);
    vecs[11] = mkv(0, 1, 0, 32'h0,        1, 32'h10,       32'h1000_0004, 4, 32'h20);
    vecs[12] = mkv(0, 1, 1, 32'h43,       0, 32'h0,        32'h0,         4, 32'h24);
    vecs[13] = mkv(0, 1, 0, 32'h0,        0, 32'h0,        32'h0,         0, 32'h40);
    vecs[14] = mkv(0, 1, 0, 32'h0,        1, 32'h40,       32'h1000_0010, 1, 32'h44);
    vecs[15] = mkv(0, 0, 1, 32'h100,      0, 32'h0,        32'h0,         1, 32'h48);
    vecs[16] = mkv(0, 0, 1, 32'h207,      0, 32'h0,        32'h0,         0, 32'h100);
    vecs[17] = mkv(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,         0, 32'h204);
    vecs[18] = mkv(0, 0, 0, 32'h0,        1, 32'h204,      32'h1000_0081, 1, 32'h208);
    vecs[19] = mkv(0, 0, 0, 32'h0,        1, 32'h204,      32'h1000_0081, 2, 32'h20C);
    vecs[20] = mkv(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,         0, 32'h0);
    vecs[21] = mkv(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,         0, 32'h0);
    vecs[22] = mkv(0, 0, 0, 32'h0,        1, 32'h0,        32'h1000_0000, 1, 32'h4);
    vecs[23] = mkv(1, 0, 1, 32'h300,      0, 32'h0,        32'h0,         0, 32'h0);
    vecs[24] = mkv(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,         0, 32'h0);
    vecs[25] = mkv(0, 0, 0, 32'h0,        1, 32'h0,        32'h1000_0000, 1, 32'h4);

    // Table-driven directed vectors on DUT 0
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      irst0 = vecs[i].rst;
      bus0.iready = vecs[i].rdy;
      bus0.iflush = vecs[i].fl;
      bus0.iflush_pc = vecs[i].flpc;
      #1;
      chk($sformatf("v%0d ovalid", i), {31'd0, bus0.ovalid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d opc", i), bus0.opc, vecs[i].epc);
      chk($sformatf("v%0d oinstr", i), bus0.oinstr, vecs[i].einstr);
      chk($sformatf("v%0d ocount", i), 32'(bus0.ocount), vecs[i].ecnt);
      chk($sformatf("v%0d omem_addr", i), addr0, vecs[i].eaddr);
      $display("vec %0d: rst=%0b rdy=%0b fl=%0b valid=%0b opc=%h instr=%h cnt=%0d addr=%h",
               i, vecs[i].rst, vecs[i].rdy, vecs[i].fl, bus0.ovalid, bus0.opc,
               bus0.oinstr, bus0.ocount, addr0);
    end

    // PC wrap through 2^32 on DUT 1 with iready held high
    @(negedge clk);
    irst1 = 1'b0;
    #1;
    chk("wrap first ovalid", {31'd0, bus1.ovalid}, 32'd0);
    chk("wrap first addr", addr1, 32'hFFFF_FFF8);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] e;
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      @(negedge clk);
      #1;
      chk($sformatf("wrap%0d ovalid", k), {31'd0, bus1.ovalid}, 32'd1);
      chk($sformatf("wrap%0d opc", k), bus1.opc, e);
      chk($sformatf("wrap%0d oinstr", k), bus1.oinstr, mem_word(e));
      chk($sformatf("wrap%0d ocount", k), 32'(bus1.ocount), 32'd1);
      $display("wrap %0d: opc=%h instr=%h", k, bus1.opc, bus1.oinstr);
    end

    // Randomised iready/iflush against a sequential-PC scoreboard on DUT 0
    @(negedge clk);
    irst0 = 1'b0; bus0.iready = 1'b0; bus0.iflush = 1'b1; bus0.iflush_pc = 32'h0000_1002;
    exp_pc = 32'h0000_1000;
    pops = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      fl  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      tgt = $urandom;
      bus0.iflush = fl;
      bus0.iflush_pc = tgt;
      bus0.iready = rdy;
      #1;
      n_checks++;
      if (32'(bus0.ocount) > 32'd4) begin
        n_fail++;
        $display("FAIL rnd%0d ocount: got %0d expected at most 4", c, bus0.ocount);
      end
      if (fl) begin
        chk($sformatf("rnd%0d flush ovalid", c), {31'd0, bus0.ovalid}, 32'd0);
        exp_pc = {tgt[31:2], 2'b00};
        $display("rnd %0d: flush to %h", c, exp_pc);
      end else if (bus0.ovalid && rdy) begin
        chk($sformatf("rnd%0d opc", c), bus0.opc, exp_pc);
        chk($sformatf("rnd%0d oinstr", c), bus0.oinstr, mem_word(exp_pc));
        $display("rnd %0d: pop opc=%h instr=%h cnt=%0d", c, bus0.opc, bus0.oinstr, bus0.ocount);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    n_checks++;
    if (pops < 50) begin
      n_fail++;
      $display("FAIL rnd pops: got %0d expected at least 50", pops);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
